cam_pattern_tx: RTL and testbench
=================================

# cam_pattern_tx

Synthetic camera source that drives the same parallel 8-bit pixel protocol our `camera` receiver consumes. It outputs pixel clock, vsync, href and byte data, with RGB565 pixels sent high byte first. It feeds the receiver in place of the physical sensor for bring-up, loopback on the `ja`/`jb` pins, and simulation. Patterns are deterministic so downstream blocks (rotate, frame buffer, threshold, center_of_mass) can be checked against known images.

## Interface
Parameters:
- `H_PIX`, 320: active pixels per line.
- `V_LINES`, 240: active lines per frame.
- `H_BLANK`, 144: href-low pclk periods after each active line.
- `VS_LINES`, 3: line times with vsync high at frame start.
- `V_BACK`, 17: blank line times after vsync.
- `V_FRONT`, 10: blank line times after the last active line.
- `CLK_DIV`, 4: clk_in cycles per pclk; even, at least 2.

Ports:
- `clk_in`, input, 1: system clock (65 MHz).
- `rst_in`, input, 1: reset, asynchronous, active-low.
- `enable_in`, input, 1: run frames while high.
- `pattern_sel_in`, input, 2: 00 colour bars, 01 ramp, 10 solid, 11 checkerboard.
- `color_in`, input, 16: RGB565 value for the solid pattern.
- `pclk_out`, output, 1: pixel clock.
- `vsync_out`, output, 1: frame sync, active high.
- `href_out`, output, 1: line valid, active high.
- `data_out`, output, 8: pixel byte.
- `frame_done_out`, output, 1: one-clk pulse at the end of active video.
- `frame_count_out`, output, 8: completed frames, wrapping.

## Operation
- Free-running divider `div_cnt` counts 0..CLK_DIV-1 from reset.
  - Rise event at `div_cnt==CLK_DIV/2-1`: `pclk_out<=1`.
  - Fall event at `div_cnt==CLK_DIV-1`: `pclk_out<=0`. `vsync_out`, `href_out` and `data_out` update on this same clk edge.
  - All state and counters advance only on fall events.
- Line time is `LT = 2*H_PIX + H_BLANK` pclk periods. The horizontal counter `hc` runs 0..LT-1 and the line counter `lc` counts within the current state.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE: outputs low. Move to VSYNC on a fall event with `enable_in`=1. On that entry, latch `pattern_sel_in` and `color_in`; they are held for the whole frame.
  - VSYNC: `vsync_out`=1 for VS_LINES*LT fall events, then VBACK.
  - VBACK: V_BACK*LT fall events, then ACTIVE.
  - ACTIVE: V_LINES lines.
    - `href_out`=1 for `hc` 0..2*H_PIX-1, then 0 for H_BLANK.
    - Byte `hc` carries pixel x=`hc>>1`, y=`lc`. Even `hc` sends `pix[15:8]`, odd `hc` sends `pix[7:0]`.
    - `data_out`=0 whenever `href_out`=0.
  - VFRONT: V_FRONT*LT fall events. At the end, go to VSYNC if `enable_in`=1, otherwise IDLE. Dropping `enable_in` mid-frame never truncates a frame.
- Patterns (pix is RGB565):
  - Colour bars: bar = x/(H_PIX/8). Values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Any remainder pixels use bar 7.
  - Ramp: `{x[8:4], y[7:2], frame_count[4:0]}`.
  - Solid: the latched `color_in`.
  - Checkerboard: FFFF if `x[4]^y[4]`, else 0000.
- `frame_done_out` pulses on the fall event that drops href after line V_LINES-1.
- `frame_count_out` increments on that same clk and wraps 255 to 0.

## Timing
- Reset values, also applied immediately on asynchronous assert:
  - `pclk_out`=0, `vsync_out`=0, `href_out`=0, `data_out`=0, `frame_done_out`=0, `frame_count_out`=0.
  - `div_cnt`=0, state IDLE.
- Reset mid-frame: all outputs return to reset values at once. After release, the block restarts from IDLE. A partial frame is never resumed.
- Every output change is registered on a fall-event clk edge, so data is stable CLK_DIV/2 clks before each pclk rise. The receiver samples on the rise.
- Startup: with `enable_in`=1 at reset release, the first fall event is at clk CLK_DIV-1 and vsync rises on it.
- Frame period: `(VS_LINES+V_BACK+V_LINES+V_FRONT)*LT*CLK_DIV` clks. Back-to-back frames have no gap.
- `enable_in` changes take effect only at frame boundaries, i.e. on entry to VSYNC from IDLE or VFRONT.

## Test plan
Common settings: H_PIX=8, V_LINES=4, H_BLANK=4, VS_LINES=1, V_BACK=1, V_FRONT=1, CLK_DIV=2, so LT=20.
- Colour bars, enable held high, sampled on pclk rise -> line 0 bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00. href high 16 pclks then low 4; vsync high 20 pclks; frame 140 pclks = 280 clks.
- Solid `color_in`=ABCD, changed to 1234 mid-frame -> every active byte pair is AB,CD for the rest of that frame; the next frame sends 12,34.
- Drop `enable_in` during ACTIVE of frame 0 -> frame 0 completes all 4 lines, then outputs stay low and `frame_count_out`=1.
- Run 256 frames of ramp -> `frame_done_out` pulses exactly 256 times, each one clk wide; `frame_count_out` wraps to 0; ramp frame 3 pixel (x=0, y=0) equals 0003.
- Assert `rst_in` low in the middle of ACTIVE -> all outputs are 0 in the same clk; after release the first vsync appears at clk 1.
- Checkerboard with H_PIX=32, V_LINES=32 -> pixel (16,0)=FFFF, (16,16)=0000, (0,16)=FFFF.

Source files
------------

// File: rtl/cam_pattern_tx.sv
// Synthetic parallel-camera source: pclk/vsync/href/byte stream carrying RGB565
// test patterns (colour bars, ramp, solid, checkerboard), high byte first.
module cam_pattern_tx #(
  parameter int H_PIX    = 320,
  parameter int V_LINES  = 240,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10,
  parameter int CLK_DIV  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [1:0]  pattern_sel_in,
  input  logic [15:0] color_in,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  data_out,
  output logic        frame_done_out,
  output logic [7:0]  frame_count_out
);

  localparam int LT    = 2*H_PIX + H_BLANK;
  localparam int HW    = $clog2(LT);
  localparam int MAX1  = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int MAX2  = (V_LINES > V_FRONT) ? V_LINES : V_FRONT;
  localparam int MAXL  = (MAX1 > MAX2) ? MAX1 : MAX2;
  localparam int LW    = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int DW    = $clog2(CLK_DIV);
  localparam int XW    = (HW - 1 > 9) ? HW - 1 : 9;
  localparam int BAR_W = (H_PIX >= 8) ? H_PIX/8 : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [LW-1:0]   lc_q, lc_d;
  logic [DW-1:0]   div_q;
  logic [1:0]      pat_q;
  logic [15:0]     color_q;
  logic            pclk_q, vsync_q, href_q, frame_done_q;
  logic [7:0]      data_q, frame_count_q;

  logic            fall_s, rise_s, last_hc_s, last_line_s, latch_s, frame_end_s;
  logic            href_s;
  logic [XW-1:0]   x_s, bar_s;
  logic [5:0]      y_s;
  logic [2:0]      bar_idx_s;
  logic [15:0]     pix_s;
  logic [7:0]      byte_s;

  function automatic logic [15:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  assign rise_s = (div_q == DW'(CLK_DIV/2 - 1));
  assign fall_s = (div_q == DW'(CLK_DIV - 1));

  // Position (state, hc, lc) that the next fall event moves to.
  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    lc_d        = lc_q;
    latch_s     = 1'b0;
    last_hc_s   = (hc_q == HW'(LT - 1));
    frame_end_s = (state_q == S_ACTIVE) && (lc_q == LW'(V_LINES - 1)) &&
                  (hc_q == HW'(2*H_PIX - 1));
    case (state_q)
      S_VSYNC:  last_line_s = (lc_q == LW'(VS_LINES - 1));
      S_VBACK:  last_line_s = (lc_q == LW'(V_BACK - 1));
      S_ACTIVE: last_line_s = (lc_q == LW'(V_LINES - 1));
      S_VFRONT: last_line_s = (lc_q == LW'(V_FRONT - 1));
      default:  last_line_s = 1'b0;
    endcase
    case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          state_d = S_VSYNC;
          hc_d    = '0;
          lc_d    = '0;
          latch_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (!last_hc_s) begin
          hc_d = hc_q + HW'(1);
        end else if (!last_line_s) begin
          hc_d = '0;
          lc_d = lc_q + LW'(1);
        end else begin
          hc_d = '0;
          lc_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            default: begin
              // Frame boundary: the only place enable_in is honoured.
              if (enable_in) begin
                state_d = S_VSYNC;
                latch_s = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Pixel and byte for the next position, using the frame-latched pattern.
  always_comb begin
    x_s       = XW'(hc_d >> 1);
    y_s       = 6'(lc_d >> 2);
    bar_s     = x_s / XW'(BAR_W);
    bar_idx_s = (bar_s > XW'(7)) ? 3'd7 : bar_s[2:0];
    case (pat_q)
      2'b00:   pix_s = bar_color(bar_idx_s);
      2'b01:   pix_s = {x_s[8:4], y_s, frame_count_q[4:0]};
      2'b10:   pix_s = color_q;
      default: pix_s = (x_s[4] ^ y_s[2]) ? 16'hFFFF : 16'h0000;
    endcase
    href_s = (state_d == S_ACTIVE) && (hc_d < HW'(2*H_PIX));
    byte_s = hc_d[0] ? pix_s[7:0] : pix_s[15:8];
  end

  // Divider, timing FSM and registered outputs; everything moves on fall events.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_q         <= '0;
      state_q       <= S_IDLE;
      hc_q          <= '0;
      lc_q          <= '0;
      pat_q         <= 2'b00;
      color_q       <= 16'h0000;
      pclk_q        <= 1'b0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'h00;
    end else begin
      frame_done_q <= 1'b0;
      div_q        <= fall_s ? '0 : div_q + DW'(1);
      if (rise_s) begin
        pclk_q <= 1'b1;
      end
      if (fall_s) begin
        pclk_q  <= 1'b0;
        state_q <= state_d;
        hc_q    <= hc_d;
        lc_q    <= lc_d;
        vsync_q <= (state_d == S_VSYNC);
        href_q  <= href_s;
        data_q  <= href_s ? byte_s : 8'h00;
        if (latch_s) begin
          pat_q   <= pattern_sel_in;
          color_q <= color_in;
        end
        if (frame_end_s) begin
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + 8'd1;
        end
      end
    end
  end

  assign pclk_out        = pclk_q;
  assign vsync_out       = vsync_q;
  assign href_out        = href_q;
  assign data_out        = data_q;
  assign frame_done_out  = frame_done_q;
  assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Self-checking bench for cam_pattern_tx: captures the byte stream once per pclk
// rise and compares it with a frame-position reference model.
`timescale 1ns/1ps
module tb_cam_pattern_tx;
  localparam int HP = 8, VL = 4, HB = 4, VS = 1, VB = 1, VF = 1, CD = 2;
  localparam int LT = 2*HP + HB;
  localparam int FRAME = (VS + VB + VL + VF) * LT;
  localparam int CK_HP = 32, CK_VL = 32, CK_LT = 2*CK_HP + HB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic en, en_ck;
  logic [1:0] pat;
  logic [15:0] col;
  logic pclk, vs, hr, fd;
  logic [7:0] d, fc;
  logic pclk_ck, vs_ck, hr_ck, fd_ck;
  logic [7:0] d_ck, fc_ck;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       cap_vs [FRAME];
  logic       cap_hr [FRAME];
  logic [7:0] cap_d  [FRAME];

  cam_pattern_tx #(.H_PIX(HP), .V_LINES(VL), .H_BLANK(HB), .VS_LINES(VS),
                   .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(CD)) dut (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en), .pattern_sel_in(pat),
    .color_in(col), .pclk_out(pclk), .vsync_out(vs), .href_out(hr),
    .data_out(d), .frame_done_out(fd), .frame_count_out(fc));

  cam_pattern_tx #(.H_PIX(CK_HP), .V_LINES(CK_VL), .H_BLANK(HB), .VS_LINES(VS),
                   .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(CD)) dut_ck (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en_ck), .pattern_sel_in(2'b11),
    .color_in(16'h0000), .pclk_out(pclk_ck), .vsync_out(vs_ck), .href_out(hr_ck),
    .data_out(d_ck), .frame_done_out(fd_ck), .frame_count_out(fc_ck));

  function automatic logic [15:0] model_pix(int pt, logic [15:0] c, int f, int x, int y, int hpix);
    int bar;
    case (pt)
      0: begin
        bar = x / (hpix / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return 16'((((x >> 4) & 31) << 11) | (((y >> 2) & 63) << 5) | (f & 31));
      2: return c;
      default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // {vsync, href, data} expected at frame position p (pclk periods from vsync rise)
  function automatic logic [9:0] model_main(int p, int pt, logic [15:0] c, int f);
    int line, h;
    logic v, e;
    logic [15:0] px;
    logic [7:0] b;
    line = p / LT;
    h    = p % LT;
    v    = (line < VS);
    e    = (line >= VS + VB) && (line < VS + VB + VL) && (h < 2*HP);
    px   = model_pix(pt, c, f, h / 2, line - VS - VB, HP);
    b    = e ? (((h % 2) == 0) ? px[15:8] : px[7:0]) : 8'h00;
    return {v, e, b};
  endfunction

  task automatic sample_main(output logic v, output logic h, output logic [7:0] b);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pclk !== 1'b1 && n < 8);
    checks++;
    if (pclk !== 1'b1) begin
      errors++;
      $display("FAIL pclk_timeout: pclk=%b required 1", pclk);
    end
    v = vs; h = hr; b = d;
  endtask

  task automatic capture(input int first, input int last);
    for (int p = first; p <= last; p++) sample_main(cap_vs[p], cap_hr[p], cap_d[p]);
  endtask

  task automatic sync_main();
    int n = 0;
    do begin
      sample_main(cap_vs[0], cap_hr[0], cap_d[0]);
      n++;
    end while (cap_vs[0] !== 1'b1 && n < 400);
    checks++;
    if (cap_vs[0] !== 1'b1) begin
      errors++;
      $display("FAIL vsync_timeout: vsync=%b required 1", cap_vs[0]);
    end
  endtask

  task automatic do_reset(input logic e, input logic [1:0] pt, input logic [15:0] c);
    rst_n = 1'b0;
    en = e; pat = pt; col = c;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad = 0, highs = 0;
    rst_n = 1'b0; en = 1'b0; en_ck = 1'b0; pat = 2'b00; col = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({pclk, vs, hr, d, fd, fc} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {pclk, vs, hr, d, fd, fc});
    end
    checks++;
    if ({pclk_ck, vs_ck, hr_ck, d_ck, fd_ck, fc_ck} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs_ck: got %h required 0", {pclk_ck, vs_ck, hr_ck, d_ck, fd_ck, fc_ck});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({vs, hr, d, fd, fc} !== 18'd0) bad++;
      if (pclk === 1'b1) highs++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active samples, required 0", bad);
    end
    checks++;
    if (highs != 50) begin
      errors++;
      $display("FAIL idle_pclk: pclk high %0d of 100 clks, required 50", highs);
    end
  endtask

  task automatic test_bars();
    logic [7:0] bars_ref [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    int t0, nvs = 0, nhr = 0;
    logic [9:0] exp;
    do_reset(1'b1, 2'b00, 16'($urandom));
    @(posedge clk); #1;
    checks++;
    if ({vs, pclk} !== 2'b01) begin
      errors++;
      $display("FAIL startup_clk0: vsync,pclk=%b required 01", {vs, pclk});
    end
    @(posedge clk); #1;
    checks++;
    if ({vs, pclk} !== 2'b10) begin
      errors++;
      $display("FAIL startup_clk1: vsync,pclk=%b required 10", {vs, pclk});
    end
    capture(0, FRAME - 1);
    t0 = int'(cyc) - 2*(FRAME - 1);
    for (int p = 0; p < FRAME; p++) begin
      exp = model_main(p, 0, 16'h0000, 0);
      checks++;
      if ({cap_vs[p], cap_hr[p], cap_d[p]} !== exp) begin
        errors++;
        $display("FAIL bars_frame p=%0d: got %h required %h", p, {cap_vs[p], cap_hr[p], cap_d[p]}, exp);
      end
      nvs += int'(cap_vs[p]);
      nhr += int'(cap_hr[p]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_d[(VS + VB)*LT + i] !== bars_ref[i]) begin
        errors++;
        $display("FAIL bars_line0 byte %0d: got %h required %h", i, cap_d[(VS + VB)*LT + i], bars_ref[i]);
      end
    end
    checks++;
    if (nvs != 20 || nhr != 64) begin
      errors++;
      $display("FAIL bars_widths: vsync %0d href %0d pclks, required 20 and 64", nvs, nhr);
    end
    sample_main(cap_vs[0], cap_hr[0], cap_d[0]);
    checks++;
    if (cap_vs[0] !== 1'b1 || int'(cyc) - t0 != 2*FRAME) begin
      errors++;
      $display("FAIL back_to_back: vsync=%b period=%0d clks, required 1 and %0d", cap_vs[0], int'(cyc) - t0, 2*FRAME);
    end
  endtask

  task automatic test_solid_latch();
    logic [9:0] exp;
    do_reset(1'b1, 2'b10, 16'hABCD);
    sync_main();
    capture(1, 49);
    col = 16'h1234;
    capture(50, FRAME - 1);
    checks++;
    if ({cap_d[50], cap_d[51]} !== 16'hABCD) begin
      errors++;
      $display("FAIL solid_held: got %h required ABCD", {cap_d[50], cap_d[51]});
    end
    for (int p = 0; p < FRAME; p++) begin
      exp = model_main(p, 2, 16'hABCD, 0);
      checks++;
      if ({cap_vs[p], cap_hr[p], cap_d[p]} !== exp) begin
        errors++;
        $display("FAIL solid_frame0 p=%0d: got %h required %h", p, {cap_vs[p], cap_hr[p], cap_d[p]}, exp);
      end
    end
    capture(0, FRAME - 1);
    checks++;
    if ({cap_d[42], cap_d[43]} !== 16'h1234) begin
      errors++;
      $display("FAIL solid_next: got %h required 1234", {cap_d[42], cap_d[43]});
    end
    for (int p = 0; p < FRAME; p++) begin
      exp = model_main(p, 2, 16'h1234, 0);
      checks++;
      if ({cap_vs[p], cap_hr[p], cap_d[p]} !== exp) begin
        errors++;
        $display("FAIL solid_frame1 p=%0d: got %h required %h", p, {cap_vs[p], cap_hr[p], cap_d[p]}, exp);
      end
    end
  endtask

  task automatic test_random_frames();
    int pc;
    logic [15:0] cc;
    logic [9:0] exp;
    do_reset(1'b1, 2'($urandom_range(3, 0)), 16'($urandom));
    pc = int'(pat); cc = col;
    sync_main();
    for (int f = 0; f < 4; f++) begin
      capture((f == 0) ? 1 : 0, 99);
      pat = 2'($urandom_range(3, 0));
      col = 16'($urandom);
      capture(100, FRAME - 1);
      for (int p = 0; p < FRAME; p++) begin
        exp = model_main(p, pc, cc, f);
        checks++;
        if ({cap_vs[p], cap_hr[p], cap_d[p]} !== exp) begin
          errors++;
          $display("FAIL random_frame%0d pat=%0d p=%0d: got %h required %h", f, pc, p, {cap_vs[p], cap_hr[p], cap_d[p]}, exp);
        end
      end
      checks++;
      if (fc !== 8'(f + 1)) begin
        errors++;
        $display("FAIL random_count%0d: got %0d required %0d", f, fc, f + 1);
      end
      pc = int'(pat); cc = col;
    end
  endtask

  task automatic test_enable_drop();
    int pc, bad = 0;
    logic [15:0] cc;
    logic [9:0] exp;
    do_reset(1'b1, 2'($urandom_range(3, 0)), 16'($urandom));
    pc = int'(pat); cc = col;
    sync_main();
    capture(1, 50);
    en = 1'b0;
    capture(51, FRAME - 1);
    for (int p = 0; p < FRAME; p++) begin
      exp = model_main(p, pc, cc, 0);
      checks++;
      if ({cap_vs[p], cap_hr[p], cap_d[p]} !== exp) begin
        errors++;
        $display("FAIL drop_frame p=%0d: got %h required %h", p, {cap_vs[p], cap_hr[p], cap_d[p]}, exp);
      end
    end
    for (int i = 0; i < 2*FRAME + 20; i++) begin
      @(negedge clk);
      if ({vs, hr, d, fd} !== 11'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_quiet: %0d active samples, required 0", bad);
    end
    checks++;
    if (fc !== 8'd1) begin
      errors++;
      $display("FAIL drop_count: got %0d required 1", fc);
    end
  endtask

  task automatic test_reset_mid();
    int pc;
    logic [15:0] cc;
    logic [9:0] exp;
    do_reset(1'b1, 2'($urandom_range(3, 0)), 16'($urandom));
    pc = int'(pat); cc = col;
    sync_main();
    capture(1, 55);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pclk, vs, hr, d, fd, fc} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h required 0", {pclk, vs, hr, d, fd, fc});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vs !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clk0: vsync=%b required 0", vs);
    end
    @(posedge clk); #1;
    checks++;
    if (vs !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_clk1: vsync=%b required 1", vs);
    end
    capture(0, FRAME - 1);
    for (int p = 0; p < FRAME; p++) begin
      exp = model_main(p, pc, cc, 0);
      checks++;
      if ({cap_vs[p], cap_hr[p], cap_d[p]} !== exp) begin
        errors++;
        $display("FAIL reset_mid_frame p=%0d: got %h required %h", p, {cap_vs[p], cap_hr[p], cap_d[p]}, exp);
      end
    end
  endtask

  task automatic test_frame_done_256();
    int pulses = 0, run = 0, width_bad = 0, fc_bad = 0, got = 0;
    logic [15:0] px = 16'hxxxx;
    do_reset(1'b1, 2'b01, 16'h0000);
    for (int i = 0; i < 256*2*FRAME + 100; i++) begin
      @(negedge clk);
      if (fd === 1'b1) begin
        run++;
        if (run == 1) begin
          pulses++;
          if (fc !== 8'(pulses)) fc_bad++;
        end
      end else begin
        if (run > 1) width_bad++;
        run = 0;
      end
      if (pulses == 3 && pclk === 1'b1 && hr === 1'b1 && got < 2) begin
        px = {px[7:0], d};
        got++;
      end
    end
    checks++;
    if (pulses != 256) begin
      errors++;
      $display("FAIL done_pulses: got %0d required 256", pulses);
    end
    checks++;
    if (width_bad != 0) begin
      errors++;
      $display("FAIL done_width: %0d wide pulses, required 0", width_bad);
    end
    checks++;
    if (fc_bad != 0) begin
      errors++;
      $display("FAIL done_count_step: %0d misaligned counts, required 0", fc_bad);
    end
    checks++;
    if (fc !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap: got %0d required 0", fc);
    end
    checks++;
    if (px !== 16'h0003) begin
      errors++;
      $display("FAIL ramp_frame3_pix00: got %h required 0003", px);
    end
  endtask

  task automatic test_checker();
    logic [15:0] pix [CK_HP][17];
    logic [15:0] exp;
    int n = 0, line, h;
    en_ck = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(pclk_ck === 1'b1 && vs_ck === 1'b1) && n < 400);
    checks++;
    if (vs_ck !== 1'b1) begin
      errors++;
      $display("FAIL ck_vsync_timeout: vsync=%b required 1", vs_ck);
    end
    for (int p = 1; p < (VS + VB + 17)*CK_LT; p++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (pclk_ck !== 1'b1 && n < 8);
      line = p / CK_LT;
      h    = p % CK_LT;
      if (line >= VS + VB && h < 2*CK_HP) begin
        if (h % 2 == 0) pix[h/2][line - VS - VB][15:8] = d_ck;
        else            pix[h/2][line - VS - VB][7:0]  = d_ck;
      end
    end
    en_ck = 1'b0;
    for (int y = 0; y < 17; y++) begin
      for (int x = 0; x < CK_HP; x++) begin
        exp = model_pix(3, 16'h0000, 0, x, y, CK_HP);
        checks++;
        if (pix[x][y] !== exp) begin
          errors++;
          $display("FAIL ck_pix (%0d,%0d): got %h required %h", x, y, pix[x][y], exp);
        end
      end
    end
    checks++;
    if (pix[16][0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL ck_16_0: got %h required FFFF", pix[16][0]);
    end
    checks++;
    if (pix[16][16] !== 16'h0000) begin
      errors++;
      $display("FAIL ck_16_16: got %h required 0000", pix[16][16]);
    end
    checks++;
    if (pix[0][16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL ck_0_16: got %h required FFFF", pix[0][16]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bars();
    test_solid_latch();
    test_random_frames();
    test_enable_drop();
    test_reset_mid();
    test_frame_done_256();
    test_checker();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
